// File: rtl/avalon_mm_pkg.sv
// Purpose: shared types, widths and helpers for the Avalon-MM test master.
// Contents: FSM state enum, bus widths, full byte-enable constant, word address helper.
package avalon_mm_pkg;

   localparam int unsigned MM_ADDR_W = 32;
   localparam int unsigned MM_DATA_W = 32;
   localparam int unsigned MM_BE_W   = 4;
   localparam int unsigned PEND_W    = 4;   // holds up to 15 outstanding reads

   localparam logic [MM_BE_W-1:0] MM_BYTEEN_ALL = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_e;

   // Byte address of 32-bit word idx relative to base (wraps modulo 2^32).
   function automatic logic [MM_ADDR_W-1:0] word_addr(input logic [MM_ADDR_W-1:0] base,
                                                     input logic [MM_ADDR_W-1:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/avalon_mm_rd_tracker.sv
// Purpose: read-side bookkeeping for the test master: outstanding-read count and
//          issue throttle, in-order return index, data check and error capture.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clear_i             start of a new test: clears all tracking state
//   en_i                read data is honoured only while high (READ/DRAIN)
//   accept_i            a read request was accepted this cycle
//   rdvalid_i/rddata_i  returned read data
//   seed_i, base_i      data of word 0 and byte address of word 0
//   can_issue_c_o       combinational: next cycle may present a read
//   pending_o           accepted-but-unreturned reads
//   rd_idx_o            number of words returned so far
//   err_count_o         saturating mismatch count
//   first_err_addr_o    address of the first mismatching word
module avalon_mm_rd_tracker
   import avalon_mm_pkg::*;
#(
   parameter int unsigned LEN_WIDTH   = 8,
   parameter int unsigned MAX_PENDING = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic                 accept_i,
   input  logic                 rdvalid_i,
   input  logic [MM_DATA_W-1:0] rddata_i,
   input  logic [MM_DATA_W-1:0] seed_i,
   input  logic [MM_ADDR_W-1:0] base_i,
   output logic                 can_issue_c_o,
   output logic [PEND_W-1:0]    pending_o,
   output logic [LEN_WIDTH-1:0] rd_idx_o,
   output logic [LEN_WIDTH-1:0] err_count_o,
   output logic [MM_ADDR_W-1:0] first_err_addr_o
);

   logic                 hit;
   logic [PEND_W-1:0]    pending_q, pending_d;
   logic [LEN_WIDTH-1:0] rd_idx_q;
   logic [LEN_WIDTH-1:0] err_count_q;
   logic [MM_ADDR_W-1:0] first_err_addr_q;
   logic [MM_DATA_W-1:0] exp_data;

   assign hit      = en_i & rdvalid_i;
   assign exp_data = seed_i + MM_DATA_W'(rd_idx_q);

   // Accept and return in the same cycle cancel out.
   always_comb begin
      pending_d = pending_q;
      if (accept_i && !hit) begin
         pending_d = pending_q + PEND_W'(1);
      end else if (!accept_i && hit) begin
         pending_d = pending_q - PEND_W'(1);
      end
   end

   // Throttle looks at the count after this cycle's accept/return.
   assign can_issue_c_o = (pending_d < PEND_W'(MAX_PENDING));

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         pending_q        <= '0;
         rd_idx_q         <= '0;
         err_count_q      <= '0;
         first_err_addr_q <= '0;
      end else begin
         pending_q <= pending_d;
         if (hit) begin
            rd_idx_q <= rd_idx_q + LEN_WIDTH'(1);
            if (rddata_i != exp_data) begin
               if (err_count_q != '1) begin
                  err_count_q <= err_count_q + LEN_WIDTH'(1);
               end
               if (err_count_q == '0) begin
                  first_err_addr_q <= word_addr(base_i, MM_ADDR_W'(rd_idx_q));
               end
            end
         end
      end
   end

   assign pending_o        = pending_q;
   assign rd_idx_o         = rd_idx_q;
   assign err_count_o      = err_count_q;
   assign first_err_addr_o = first_err_addr_q;

endmodule

// File: rtl/avalon_mm_test_master.sv
// Purpose: Avalon-MM initiator that writes an incrementing run of words, reads them
//          back with pipelined reads and reports pass/fail.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i                  start pulse (ignored unless idle)
//   base_addr_i, length_i,   test parameters, sampled on the start cycle
//   seed_i
//   busy_o, done_o, pass_o   status; done_o is a one-cycle pulse
//   err_count_o              saturating mismatch count
//   first_err_addr_o         address of first mismatching word (0 if none)
//   mm_*                     Avalon-MM initiator interface
module avalon_mm_test_master
   import avalon_mm_pkg::*;
#(
   parameter int unsigned LEN_WIDTH   = 8,
   parameter int unsigned MAX_PENDING = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [MM_ADDR_W-1:0] base_addr_i,
   input  logic [LEN_WIDTH-1:0] length_i,
   input  logic [MM_DATA_W-1:0] seed_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [LEN_WIDTH-1:0] err_count_o,
   output logic [MM_ADDR_W-1:0] first_err_addr_o,
   output logic [MM_ADDR_W-1:0] mm_addr_o,
   output logic [MM_BE_W-1:0]   mm_byteen_o,
   output logic                 mm_read_o,
   output logic                 mm_write_o,
   output logic [MM_DATA_W-1:0] mm_wrdata_o,
   input  logic [MM_DATA_W-1:0] mm_rddata_i,
   input  logic                 mm_rdvalid_i,
   input  logic                 mm_wait_i
);

   state_e               state_q;
   logic [MM_ADDR_W-1:0] base_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [MM_DATA_W-1:0] seed_q;
   logic [LEN_WIDTH-1:0] wr_idx_q, rd_iss_q;
   logic [LEN_WIDTH-1:0] wr_idx_inc, rd_iss_inc;
   logic [MM_ADDR_W-1:0] mm_addr_q;
   logic [MM_BE_W-1:0]   mm_byteen_q;
   logic                 mm_read_q, mm_write_q;
   logic [MM_DATA_W-1:0] mm_wrdata_q;
   logic                 busy_q, done_q, pass_q;

   logic                 wr_acc, rd_acc, trk_clear, trk_en, can_issue_c;
   logic [MM_ADDR_W-1:0] base_aligned;
   logic [PEND_W-1:0]    pending;
   logic [LEN_WIDTH-1:0] rd_idx, err_count;

   assign base_aligned = base_addr_i & ~MM_ADDR_W'(3);
   assign wr_acc       = mm_write_q & ~mm_wait_i;
   assign rd_acc       = mm_read_q & ~mm_wait_i;
   assign wr_idx_inc   = wr_idx_q + LEN_WIDTH'(1);
   assign rd_iss_inc   = rd_iss_q + LEN_WIDTH'(1);
   assign trk_clear    = (state_q == IDLE) && start_i;
   assign trk_en       = (state_q == READ) || (state_q == DRAIN);

   avalon_mm_rd_tracker #(
      .LEN_WIDTH   (LEN_WIDTH),
      .MAX_PENDING (MAX_PENDING)
   ) u_rd_tracker (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .clear_i          (trk_clear),
      .en_i             (trk_en),
      .accept_i         (rd_acc),
      .rdvalid_i        (mm_rdvalid_i),
      .rddata_i         (mm_rddata_i),
      .seed_i           (seed_q),
      .base_i           (base_q),
      .can_issue_c_o    (can_issue_c),
      .pending_o        (pending),
      .rd_idx_o         (rd_idx),
      .err_count_o      (err_count),
      .first_err_addr_o (first_err_addr_o)
   );

   // Test sequencer with registered bus and status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         seed_q      <= '0;
         wr_idx_q    <= '0;
         rd_iss_q    <= '0;
         mm_addr_q   <= '0;
         mm_byteen_q <= '0;
         mm_read_q   <= 1'b0;
         mm_write_q  <= 1'b0;
         mm_wrdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  base_q   <= base_aligned;
                  len_q    <= length_i;
                  seed_q   <= seed_i;
                  wr_idx_q <= '0;
                  rd_iss_q <= '0;
                  pass_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  if (length_i != '0) begin
                     state_q     <= WRITE;
                     mm_write_q  <= 1'b1;
                     mm_byteen_q <= MM_BYTEEN_ALL;
                     mm_addr_q   <= base_aligned;
                     mm_wrdata_q <= seed_i;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            WRITE: begin
               if (wr_acc) begin
                  if (wr_idx_q == len_q - LEN_WIDTH'(1)) begin
                     // Last write taken: first read goes out next cycle, nothing pending yet.
                     state_q    <= READ;
                     mm_write_q <= 1'b0;
                     mm_read_q  <= 1'b1;
                     mm_addr_q  <= base_q;
                  end else begin
                     wr_idx_q    <= wr_idx_inc;
                     mm_addr_q   <= word_addr(base_q, MM_ADDR_W'(wr_idx_inc));
                     mm_wrdata_q <= seed_q + MM_DATA_W'(wr_idx_inc);
                  end
               end
            end
            READ: begin
               if (rd_acc) begin
                  rd_iss_q <= rd_iss_inc;
                  if (rd_iss_inc == len_q) begin
                     state_q     <= DRAIN;
                     mm_read_q   <= 1'b0;
                     mm_byteen_q <= '0;
                  end else begin
                     mm_addr_q <= word_addr(base_q, MM_ADDR_W'(rd_iss_inc));
                     mm_read_q <= can_issue_c;
                  end
               end else begin
                  mm_read_q <= can_issue_c;
               end
            end
            DRAIN: begin
               if ((pending == '0) && (rd_idx == len_q)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               pass_q  <= (err_count == '0);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign err_count_o = err_count;
   assign mm_addr_o   = mm_addr_q;
   assign mm_byteen_o = mm_byteen_q;
   assign mm_read_o   = mm_read_q;
   assign mm_write_o  = mm_write_q;
   assign mm_wrdata_o = mm_wrdata_q;

endmodule

// File: tb/tb_avalon_mm_test_master.sv
// Purpose: self-checking bench for avalon_mm_test_master. A RAM-style responder with
//          random waits, configurable read latency and optional corruption; a
//          word-level model of the test derives every expected bus transfer and result.
`timescale 1ns/1ps
module tb_avalon_mm_test_master;

   localparam int unsigned LW   = 8;
   localparam int unsigned MAXP = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   base_addr = '0;
   logic [LW-1:0] length = '0;
   logic [31:0]   seed = '0;
   logic          busy, done_o, pass;
   logic [LW-1:0] err_count;
   logic [31:0]   first_err_addr, mm_addr, mm_wrdata;
   logic [3:0]    mm_byteen;
   logic          mm_read, mm_write;
   logic [31:0]   mm_rddata = '0;
   logic          mm_rdvalid = 1'b0;
   logic          mm_wait = 1'b0;

   always #5 clk = ~clk;

   avalon_mm_test_master #(.LEN_WIDTH(LW), .MAX_PENDING(MAXP)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
      .length_i(length), .seed_i(seed), .busy_o(busy), .done_o(done_o), .pass_o(pass),
      .err_count_o(err_count), .first_err_addr_o(first_err_addr),
      .mm_addr_o(mm_addr), .mm_byteen_o(mm_byteen), .mm_read_o(mm_read),
      .mm_write_o(mm_write), .mm_wrdata_o(mm_wrdata), .mm_rddata_i(mm_rddata),
      .mm_rdvalid_i(mm_rdvalid), .mm_wait_i(mm_wait)
   );

   int total = 0;
   int bad   = 0;

   // responder configuration
   int          cfg_wait_pct = 0;
   int          cfg_lat = 1;
   bit          cfg_corrupt = 1'b0;
   logic [31:0] cfg_corrupt_addr = '0;
   bit          cfg_stray = 1'b0;

   // word-level model of the running test
   bit          armed = 0, run_active = 0, prev_rst = 0, prev_waited = 0, chk_busy_next = 0;
   logic        prev_rd = 0, prev_wr = 0;
   logic [31:0] prev_addr = '0, prev_wrdata = '0;
   logic [31:0] m_base = '0, m_seed = '0;
   int          m_len = 0, wr_cnt = 0, rd_iss = 0, rd_ret = 0, outst = 0, max_out = 0;
   int          req_cycles = 0, done_cnt = 0, start_cyc = 0, done_lat = 0, cyc = 0;
   bit          e_pass = 0, h_pass = 0;
   int          e_err = 0, h_err = 0;
   logic [31:0] e_first = '0, h_first = '0;
   logic [31:0] first_wr_addr = '0, first_wr_data = '0;
   logic [31:0] ram [logic [31:0]];

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;
   rsp_t rq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Responder and per-cycle compare, both on the falling edge.
   always @(negedge clk) begin
      logic        w, rv;
      logic [31:0] d, a, dd;
      cyc++;
      if (rst) begin
         mm_wait = 1'b0; mm_rdvalid = 1'b0; mm_rddata = '0;
         rq.delete(); outst = 0; run_active = 0; prev_waited = 0; chk_busy_next = 0;
         armed = 1; prev_rst = 1;
         h_pass = 0; h_err = 0; h_first = '0;
      end else if (armed) begin
         if (prev_rst) begin
            chk("rst_busy", busy, 0);        chk("rst_done", done_o, 0);
            chk("rst_pass", pass, 0);        chk("rst_err", err_count, 0);
            chk("rst_first", first_err_addr, 0);
            chk("rst_read", mm_read, 0);     chk("rst_write", mm_write, 0);
            chk("rst_addr", mm_addr, 0);     chk("rst_byteen", mm_byteen, 0);
            chk("rst_wrdata", mm_wrdata, 0);
            prev_rst = 0;
         end
         if (chk_busy_next) begin
            chk("busy_after_start", busy, 1);
            chk_busy_next = 0;
         end
         if (prev_waited) begin
            chk("hold_read", mm_read, prev_rd);
            chk("hold_write", mm_write, prev_wr);
            chk("hold_addr", mm_addr, prev_addr);
            if (prev_wr) chk("hold_wrdata", mm_wrdata, prev_wrdata);
         end
         if (mm_read || mm_write) begin
            req_cycles++;
            chk("byteen", mm_byteen, 4'hF);
         end
         // expected request pattern from the phase of the modelled test
         if (!run_active) begin
            chk("idle_no_req", mm_read | mm_write, 0);
         end else if (wr_cnt < m_len) begin
            chk("wr_phase_write", mm_write, 1);
            chk("wr_phase_read", mm_read, 0);
         end else if (rd_iss < m_len) begin
            chk("rd_phase_write", mm_write, 0);
            chk("rd_throttle", mm_read, outst < int'(MAXP));
         end else begin
            chk("drain_no_req", mm_read | mm_write, 0);
         end
         if (done_o) begin
            done_cnt++;
            chk("done_expected", run_active, 1);
            chk("done_busy", busy, 0);
            chk("done_pass", pass, e_pass);
            chk("done_err", err_count, e_err);
            chk("done_first", first_err_addr, e_first);
            chk("done_wr_count", wr_cnt, m_len);
            chk("done_rd_count", rd_ret, m_len);
            done_lat = cyc - start_cyc;
            run_active = 0;
            h_pass = e_pass; h_err = e_err; h_first = e_first;
         end else if (!busy) begin
            chk("idle_pass", pass, h_pass);
            chk("idle_err", err_count, h_err);
            chk("idle_first", first_err_addr, h_first);
         end else if (run_active) begin
            chk("busy_pass_clear", pass, 0);
         end

         w = (cfg_wait_pct > 0) && ($urandom_range(99, 0) < cfg_wait_pct);
         if (mm_write && !w) begin
            chk("wr_in_range", wr_cnt < m_len, 1);
            chk("wr_no_outstanding", outst, 0);
            chk("wr_addr", mm_addr, m_base + 32'(wr_cnt) * 4);
            chk("wr_data", mm_wrdata, m_seed + 32'(wr_cnt));
            if (wr_cnt == 0) begin first_wr_addr = mm_addr; first_wr_data = mm_wrdata; end
            ram[mm_addr] = mm_wrdata;
            wr_cnt++;
         end
         if (mm_read && !w) begin
            chk("rd_in_range", rd_iss < m_len, 1);
            chk("rd_addr", mm_addr, m_base + 32'(rd_iss) * 4);
            if (cfg_corrupt && mm_addr == cfg_corrupt_addr) dd = 32'hDEADBEEF;
            else if (ram.exists(mm_addr)) dd = ram[mm_addr];
            else dd = 32'h0;
            rq.push_back('{due: cyc + cfg_lat, data: dd});
            outst++;
            rd_iss++;
         end
         rv = 1'b0;
         d  = $urandom;
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            rv = 1'b1; d = rq[0].data; rq.delete(0); outst--; rd_ret++;
         end else if (cfg_stray && outst == 0 && (!busy || (run_active && wr_cnt < m_len))
                      && $urandom_range(3, 0) == 0) begin
            rv = 1'b1;   // stray beat while nothing is being read back
         end
         chk("max_outstanding", outst > int'(MAXP), 0);
         if (outst > max_out) max_out = outst;

         if (start && !busy) begin
            m_base = base_addr & ~32'h3; m_len = int'(length); m_seed = seed;
            wr_cnt = 0; rd_iss = 0; rd_ret = 0; max_out = 0; req_cycles = 0;
            start_cyc = cyc; ram.delete();
            e_err = 0; e_first = '0;
            for (int i = 0; i < m_len; i++) begin
               a = m_base + 32'(i) * 4;
               dd = (cfg_corrupt && a == cfg_corrupt_addr) ? 32'hDEADBEEF : m_seed + 32'(i);
               if (dd != m_seed + 32'(i)) begin
                  if (e_err == 0) e_first = a;
                  if (e_err < 255) e_err++;
               end
            end
            e_pass = (e_err == 0);
            run_active = 1; chk_busy_next = 1;
         end

         mm_wait = w; mm_rdvalid = rv; mm_rddata = d;
         prev_waited = (mm_read || mm_write) && w;
         prev_rd = mm_read; prev_wr = mm_write; prev_addr = mm_addr; prev_wrdata = mm_wrdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_test(input logic [31:0] b, input int len, input logic [31:0] s,
                           input int wp, input int lat, input bit cor,
                           input logic [31:0] caddr, input bit extra);
      int d0;
      cfg_wait_pct = wp; cfg_lat = lat; cfg_corrupt = cor; cfg_corrupt_addr = caddr;
      base_addr = b; length = LW'(len); seed = s; start = 1'b1;
      d0 = done_cnt;
      tick();
      start = 1'b0; base_addr = $urandom; length = LW'($urandom); seed = $urandom;
      for (int i = 0; i < 5000 && done_cnt == d0; i++) begin
         start = (extra && i == 3);
         tick();
      end
      start = 1'b0;
      chk("done_seen", done_cnt - d0, 1);
      repeat (3) tick();
      chk("single_done", done_cnt - d0, 1);
   endtask

   initial begin
      int          d0, ln;
      logic [31:0] b;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // zero-wait basic run
      run_test(32'h1000, 4, 32'hA5A50000, 0, 1, 0, '0, 0);
      chk("t1_first_wr_addr", first_wr_addr, 32'h1000);
      chk("t1_first_wr_data", first_wr_data, 32'hA5A50000);
      chk("t1_pass", pass, 1);
      chk("t1_err", err_count, 0);
      chk("t1_first_err", first_err_addr, 0);

      // ~50% waitrequest, stray beats, extra start while busy
      cfg_stray = 1'b1;
      run_test(32'h1000, 4, 32'hA5A50000, 50, 1, 0, '0, 1);
      chk("t2_pass", pass, 1);
      chk("t2_err", err_count, 0);

      // corrupted word at 0x1008
      run_test(32'h1000, 4, 32'hA5A50000, 0, 1, 1, 32'h1008, 0);
      chk("t3_pass", pass, 0);
      chk("t3_err", err_count, 1);
      chk("t3_first_err", first_err_addr, 32'h1008);

      // long read latency exercises the pending throttle
      run_test(32'h2000, 16, 32'h0000_1234, 0, 6, 0, '0, 0);
      chk("t4_max_outstanding", max_out, MAXP);
      chk("t4_pass", pass, 1);

      // zero-length test
      run_test(32'h3000, 0, 32'h5555_0000, 0, 1, 0, '0, 0);
      chk("t5_no_traffic", req_cycles, 0);
      chk("t5_done_latency", done_lat, 2);
      chk("t5_pass", pass, 1);
      chk("t5_err", err_count, 0);

      // reset in the middle of the read phase
      cfg_wait_pct = 30; cfg_lat = 3; cfg_corrupt = 0;
      base_addr = 32'h4000; length = LW'(20); seed = 32'h0BAD_0000; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2000 && rd_iss == 0; i++) tick();
      chk("t6_reached_read", rd_iss > 0, 1);
      tick();
      d0 = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (40) tick();
      chk("t6_no_done_after_rst", done_cnt, d0);
      run_test(32'h4000, 20, 32'h0BAD_0000, 30, 3, 0, '0, 0);
      chk("t6_clean_pass", pass, 1);

      // randomized runs, including an address wrap and a maximum-length run
      for (int t = 0; t < 12; t++) begin
         b  = (t == 0) ? 32'hFFFF_FFF0 : $urandom;
         ln = (t == 1) ? 255 : int'($urandom_range(40, 1));
         run_test(b, ln, $urandom, int'($urandom_range(70, 0)), int'($urandom_range(7, 1)),
                  bit'($urandom_range(1, 0)),
                  (b & ~32'h3) + 32'($urandom_range(ln - 1, 0)) * 4, bit'($urandom_range(1, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
